multi_ball_pattern_gen: RTL

- Parametrised successor to the single-ball VGA test-pattern generator.
- Animates N_BALLS square sprites that bounce off all four edges of the active area.
- Selectable background mode.
- Sits between vgaDriver (supplies pixel coordinates and a frame tick) and the driver's rgb_i input. Fully synchronous: one clock, no sync-derived clocks.

---
 rtl/vga_pattern_pkg.sv | 57 +++++
 rtl/ball_mover.sv | 57 +++++
 rtl/multi_ball_pattern_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared colour constants, mode encodings and per-axis motion helpers
// for the multi-ball VGA test-pattern generator.
package vga_pattern_pkg;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] WHITE   = 16'hFFFF;

    // Packed so that element 0 is the rightmost term: PALETTE[0] = WHITE.
    localparam logic [7:0][15:0] PALETTE =
        {BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE};

    typedef enum logic [1:0] {
        MODE_BALLS = 2'b00,
        MODE_CROSS = 2'b01,
        MODE_GRID  = 2'b10,
        MODE_BARS  = 2'b11
    } mode_e;

    typedef logic signed [4:0] vel_t;

    typedef struct packed {
        logic [15:0] pos;
        vel_t        vel;
        logic        hit;
    } axis_t;

    // One axis of one update: clamp to [0, bound] and reflect on overshoot.
    // Landing exactly on a bound is not a reflection.
    function automatic axis_t axis_step(input logic [15:0] pos, input vel_t vel,
                                        input logic [15:0] bound);
        axis_t             res;
        logic signed [16:0] n;
        n   = $signed({1'b0, pos}) + $signed({{12{vel[4]}}, vel});
        res = '{pos: n[15:0], vel: vel, hit: 1'b0};
        if (n < 0) begin
            res = '{pos: 16'd0, vel: -vel, hit: 1'b1};
        end else if (n > $signed({1'b0, bound})) begin
            res = '{pos: bound, vel: -vel, hit: 1'b1};
        end
        return res;
    endfunction

    // Unsigned wrap turns "pos left of origin" into a huge difference.
    function automatic logic in_band(input logic [15:0] pos, input logic [15:0] origin,
                                     input logic [15:0] size);
        logic [15:0] d;
        d = pos - origin;
        return d < size;
    endfunction

endpackage

// File: rtl/ball_mover.sv
// One bouncing sprite: holds position and velocity, applies the
// clamp/reflect rule on each step and flags the update that bounced.
module ball_mover
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SIZE     = 4,
    parameter int SPEED    = 2,
    parameter int X0       = 128,
    parameter int Y0       = 128,
    parameter bit VX_NEG   = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        step_i,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic        collide_o
);

    localparam logic [15:0] X_MAX  = 16'(H_ACTIVE - SIZE);
    localparam logic [15:0] Y_MAX  = 16'(V_ACTIVE - SIZE);
    localparam vel_t        V_INIT = vel_t'(SPEED);

    vel_t  vx;
    vel_t  vy;
    axis_t nxt_x;
    axis_t nxt_y;

    always_comb begin
        nxt_x = axis_step(x_o, vx, X_MAX);
        nxt_y = axis_step(y_o, vy, Y_MAX);
    end

    // NOTE: state registers use non-blocking assignments so every ball
    // samples the same pre-edge values and updates in parallel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_o       <= 16'(X0);
            y_o       <= 16'(Y0);
            vx        <= VX_NEG ? -V_INIT : V_INIT;
            vy        <= V_INIT;
            collide_o <= 1'b0;
        end else begin
            collide_o <= 1'b0;
            if (step_i) begin
                x_o       <= nxt_x.pos;
                vx        <= nxt_x.vel;
                y_o       <= nxt_y.pos;
                vy        <= nxt_y.vel;
                collide_o <= nxt_x.hit | nxt_y.hit;
            end
        end
    end

endmodule

// File: rtl/multi_ball_pattern_gen.sv
// Multi-ball VGA test pattern: N bouncing sprites over a selectable
// background, one registered RGB565 pixel per clock.
module multi_ball_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int N_BALLS  = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SIZE     = 4,
    parameter int SPEED    = 2,
    parameter int HINIT    = 128,
    parameter int VINIT    = 128,
    parameter int SPACING  = 40
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_tick_i,
    input  logic [15:0]        hpos_i,
    input  logic [15:0]        vpos_i,
    input  logic               pause_i,
    input  logic [1:0]         mode_i,
    output logic [15:0]        rgb_o,
    output logic [N_BALLS-1:0] collide_o
);

    localparam logic [15:0] SZ = 16'(SIZE);

    logic               step;
    logic [15:0]        ball_x [N_BALLS];
    logic [15:0]        ball_y [N_BALLS];
    logic [N_BALLS-1:0] hit;
    logic [2:0]         bar_idx;
    logic [15:0]        bg;
    logic [15:0]        pix;
    logic               active;

    assign step = frame_tick_i & ~pause_i;

    for (genvar k = 0; k < N_BALLS; k++) begin : g_ball
        ball_mover #(
            .H_ACTIVE (H_ACTIVE),
            .V_ACTIVE (V_ACTIVE),
            .SIZE     (SIZE),
            .SPEED    (SPEED),
            .X0       (HINIT + k * SPACING),
            .Y0       (VINIT + k * SPACING),
            .VX_NEG   ((k % 2) == 1)
        ) u_ball (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .step_i    (step),
            .x_o       (ball_x[k]),
            .y_o       (ball_y[k]),
            .collide_o (collide_o[k])
        );

        assign hit[k] = in_band(hpos_i, ball_x[k], SZ) && in_band(vpos_i, ball_y[k], SZ);
    end

    assign active = (hpos_i < 16'(H_ACTIVE)) && (vpos_i < 16'(V_ACTIVE));

    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        bar_idx = 3'd0;
        bg      = BLACK;
        pix     = BLACK;

        // Bar index = floor(hpos*8/H_ACTIVE) as a ladder of threshold compares.
        for (int i = 1; i < 8; i++) begin
            if (hpos_i >= 16'((i * H_ACTIVE + 7) / 8)) bar_idx = 3'(i);
        end

        case (mode_e'(mode_i))
            MODE_CROSS: begin
                if (in_band(hpos_i, ball_x[0], SZ))      bg = BLUE;
                else if (in_band(vpos_i, ball_y[0], SZ)) bg = RED;
            end
            MODE_GRID: begin
                if (hpos_i[2:0] == 3'd0 || vpos_i[2:0] == 3'd0) bg = RED;
                else if (hpos_i[4])                             bg = GREEN;
                else if (vpos_i[4])                             bg = BLUE;
            end
            MODE_BARS: bg = PALETTE[bar_idx];
            default:   bg = BLACK;
        endcase

        // Walk from the highest index down so the lowest covering ball wins.
        pix = bg;
        for (int k = N_BALLS - 1; k >= 0; k--) begin
            if (hit[k]) pix = PALETTE[3'(k)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) rgb_o <= BLACK;
        else         rgb_o <= active ? pix : BLACK;
    end

endmodule
